// File: rtl/fifo_uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit.
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic bit_end
);

  localparam int            TW   = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  // load restarts the bit period on state entry; otherwise wrap at LAST
  always_ff @(posedge clk) begin
    if (!rst_n)                   cnt <= '0;
    else if (load || cnt == LAST) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the byte FIFO and serializes them as back-to-back UART frames.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_t        state, state_n;
  logic [WIDTH-1:0] shift;
  logic             par;
  logic [IW-1:0]    bit_idx;
  logic             stop_cnt;
  logic             bit_end;
  logic             last_stop;
  logic             pop;
  logic             load;

  assign last_stop = (state == STOP) && bit_end && (stop_cnt == 1'(STOP_BITS - 1));
  // rst_n gate keeps the FIFO untouched while reset is held
  assign pop       = rst_n && enable && !fifo_empty && ((state == IDLE) || last_stop);
  assign load      = (state_n != state);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pop) state_n = START;
      START:   if (bit_end) state_n = DATA;
      DATA:    if (bit_end && bit_idx == IW'(WIDTH - 1))
                 state_n = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bit_end) state_n = STOP;
      STOP:    if (last_stop) state_n = pop ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // parity is taken from the word at capture, so later fifo_data changes cannot leak in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift    <= '0;
      par      <= 1'b0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      if (pop) begin
        shift <= fifo_data;
        par   <= (^fifo_data) ^ (PARITY_ODD != 0);
      end else if (state == DATA && bit_end) begin
        shift <= shift >> 1;
      end

      if (state != DATA) bit_idx <= '0;
      else if (bit_end)  bit_idx <= bit_idx + 1'b1;

      if (state != STOP) stop_cnt <= 1'b0;
      else if (bit_end)  stop_cnt <= ~stop_cnt;
    end
  end

  always_comb begin
    tx         = 1'b1;
    busy       = (state != IDLE);
    frame_done = last_stop;
    fifo_read  = pop;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      PARITY:  tx = par;
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Three transmitter configurations share one FIFO image; each is checked cycle by cycle against a frame-level model.
module tb_fifo_uart_tx;

  localparam int NP  = 3;
  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] mem [256];
  int         wp;
  int         vectors;
  int         errs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s[%0d] t=%0t got %0h expected %0h", tag, idx, $time, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NP; g++) begin : g_dut
    localparam int PEN  = (g > 0) ? 1 : 0;
    localparam int PODD = (g == 2) ? 1 : 0;
    localparam int SB   = (g == 1) ? 2 : 1;

    logic       tx, busy, fd, rd, empty;
    logic [7:0] data;
    int         rp = 0;
    int         n_fd = 0;
    int         n_rd = 0;
    bit         q[$];

    assign empty = (rp >= wp);
    assign data  = mem[rp[7:0]];

    fifo_uart_tx #(
      .WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(PEN), .PARITY_ODD(PODD), .STOP_BITS(SB)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .fifo_empty(empty),
      .fifo_data (data),
      .fifo_read (rd),
      .tx        (tx),
      .busy      (busy),
      .frame_done(fd)
    );

    always @(posedge clk) if (rd) rp <= rp + 1;

    // q holds the expected tx value for each upcoming cycle of the frame in flight
    initial begin
      bit         e_tx, e_busy, e_fd, e_rd;
      logic [7:0] d;
      @(posedge clk);
      forever begin
        @(negedge clk);
        e_tx = 1'b1; e_busy = 1'b0; e_fd = 1'b0;
        if (q.size() > 0) begin
          e_tx   = q.pop_front();
          e_busy = 1'b1;
          e_fd   = (q.size() == 0);
        end
        e_rd = rst_n && enable && (rp < wp) && (q.size() == 0);
        chk("tx", g, 32'(tx), 32'(e_tx));
        chk("busy", g, 32'(busy), 32'(e_busy));
        chk("frame_done", g, 32'(fd), 32'(e_fd));
        chk("fifo_read", g, 32'(rd), 32'(e_rd));
        if (fd) n_fd++;
        if (rd) n_rd++;
        if (!rst_n) q.delete();
        else if (e_rd) begin
          d = mem[rp[7:0]];
          for (int k = 0; k < CPB; k++) q.push_back(1'b0);
          for (int i = 0; i < 8; i++)
            for (int k = 0; k < CPB; k++) q.push_back(d[i]);
          if (PEN != 0)
            for (int k = 0; k < CPB; k++) q.push_back((^d) ^ (PODD != 0));
          for (int k = 0; k < CPB * SB; k++) q.push_back(1'b1);
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wp[7:0]] = b;
    wp++;
  endtask

  function automatic bit drained();
    return g_dut[0].rp == wp && g_dut[0].q.size() == 0 &&
           g_dut[1].rp == wp && g_dut[1].q.size() == 0 &&
           g_dut[2].rp == wp && g_dut[2].q.size() == 0;
  endfunction

  task automatic wait_drain();
    int t = 0;
    while (!drained() && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) chk("drain_timeout", 0, 32'd1, 32'd0);
  endtask

  // leaves the caller #1 after the edge that ends the pop cycle
  task automatic wait_rd();
    int t = 0;
    bit seen = 1'b0;
    while (!seen && t < 200) begin
      @(negedge clk);
      seen = g_dut[0].rd;
      t++;
    end
    if (!seen) chk("pop_timeout", 0, 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0_fd, n0_rd;
    vectors = 0; errs = 0; wp = 0;
    rst_n = 1'b0; enable = 1'b1;

    // FIFO non-empty during reset: no pop until rst_n rises
    push(8'hA5);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain();

    n0_fd = g_dut[0].n_fd; n0_rd = g_dut[0].n_rd;
    push(8'h00); push(8'hFF);
    wait_drain();
    chk("b2b_frame_done", 0, 32'(g_dut[0].n_fd - n0_fd), 32'd2);
    chk("b2b_pops", 0, 32'(g_dut[0].n_rd - n0_rd), 32'd2);

    push(8'h07);
    wait_drain();

    // enable dropped in data bit 3 with words still queued
    push(8'h5A); push(8'hC3); push(8'h81);
    wait_rd();
    repeat (17) @(posedge clk);
    #1 enable = 1'b0;
    n0_rd = g_dut[0].n_rd;
    repeat (80) @(posedge clk);
    chk("hold_pops", 0, 32'(g_dut[0].n_rd - n0_rd), 32'd0);
    #1 enable = 1'b1;
    wait_drain();

    // reset in data bit 3; the next word must still go out whole
    push(8'h3C); push(8'h96);
    n0_fd = g_dut[0].n_fd;
    wait_rd();
    repeat (17) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain();
    chk("rst_frame_done", 0, 32'(g_dut[0].n_fd - n0_fd), 32'd1);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) != 0) push(8'($urandom));
      enable = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(1, 30)) @(posedge clk);
      #1;
    end
    enable = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
